bcrypt_tx_arbiter: RTL and testbench
====================================

Name: bcrypt_tx_arbiter

Overview:
- Sequences the bcrypt data/init broadcaster onto N_CORES bcrypt cores that share one 10-bit input bus.
- Decides which core receives the next init load (P/MW/S constants) or data batch, and issues start_init_tx/start_data_tx.
- Selects the receiving core via a one-hot write enable.
- Handles per-packet accounting: dispatch stalls at a packet's gen_end until all cores finish, then a pkt_done pulse is emitted.

Parameters:
N_CORES, 4, number of cores sharing the bus (2..16)
CNT_W, 16, width of per-packet candidate counter

Ports:
CLK  in  1  clock
rst  in  1  synchronous active-high reset
data_ready  in  1  data batch available in broadcaster
init_ready  in  1  broadcaster able to send init
bcdata_pkt_id  in  16  pkt_id of pending batch
bcdata_gen_end  in  1  pending batch is the gen_end dummy
start_init_tx  out  1  1-cycle pulse, begin init transmit
start_data_tx  out  1  1-cycle pulse, begin data transmit
init_tx_done  in  1  1-cycle pulse, init transmit finished
data_tx_done  in  1  1-cycle pulse, data transmit finished
core_ready  in  N_CORES  core can accept input
core_done  in  N_CORES  1-cycle pulse, core finished its batch
core_wr_en  out  N_CORES  one-hot, core latching the bus
pkt_done  out  1  1-cycle pulse, packet fully processed
pkt_done_id  out  16  pkt_id, valid with pkt_done
pkt_cand_count  out  CNT_W  candidates dispatched in packet, valid with pkt_done
error  out  2  sticky error flags

Behaviour:
- Reset: all outputs 0; FSM is IDLE; rr pointer is 0; per-core init_done=0 and busy=0; outstanding=0; cand counter=0. Reset mid-transfer abandons it, and every core requires re-init.
- Eligibility:
  - init-eligible(i) = core_ready[i] & ~busy[i] & ~init_done[i].
  - data-eligible(i) = core_ready[i] & ~busy[i] & init_done[i].
  - Both use registered busy/init_done.
- Selection: round-robin. Search starts at the rr pointer, ascending with wrap. After a grant to core i, pointer <= (i+1) mod N_CORES.
- FSM:
  - IDLE, priority order:
    1. If any init-eligible core and init_ready: pulse start_init_tx, set core_wr_en to the granted core, go INIT_WAIT.
    2. Else if data_ready & bcdata_gen_end: latch bcdata_pkt_id, pulse start_data_tx with core_wr_en=0, go GEN_END_WAIT.
    3. Else if data_ready & ~bcdata_gen_end & any data-eligible core: pulse start_data_tx, set core_wr_en one-hot, set busy[i], outstanding+1, cand counter+1, go DATA_WAIT.
  - INIT_WAIT: hold core_wr_en. On init_tx_done set init_done[i], go IDLE. core_wr_en drops the cycle after the done pulse.
  - DATA_WAIT: hold core_wr_en. On data_tx_done go IDLE. core_wr_en drops the cycle after.
  - GEN_END_WAIT: on data_tx_done go DRAIN.
  - DRAIN: no dispatch. When outstanding==0 (including the cycle it reaches 0), go PKT_DONE.
  - PKT_DONE: pulse pkt_done with pkt_done_id=latched id and pkt_cand_count=cand counter. Clear cand counter, go IDLE.
  - ERROR: outputs held 0 except error. Exit only via rst.
- core_done[i]: clears busy[i] and decrements outstanding in any state except ERROR. A dispatch and a core_done in the same cycle give a net outstanding change of 0. Multiple core_done bits in one cycle all count.
- Errors (sticky, go to ERROR):
  - error[0]: init_tx_done outside INIT_WAIT, or data_tx_done outside DATA_WAIT/GEN_END_WAIT.
  - error[1]: core_done[i] with busy[i]=0.
- Latency: a grant decision is registered, so the start pulse and core_wr_en appear 1 cycle after eligibility is seen. There is at most one transfer in flight on the bus.
- Counter widths: outstanding is clog2(N_CORES+1) bits and cannot overflow, since it is bounded by busy bits. The cand counter saturates at its maximum.

Test Plan:
- After reset with core_ready=4'b1111 and init_ready=1: 4 init transfers to cores 0,1,2,3 in order, each with core_wr_en one-hot, then no further start_init_tx.
- After init, data_ready held with 6 batches and core_ready=1111, core_done withheld: 4 data grants to cores 0..3, then stall. core_done[2] -> next grant goes to core 2.
- gen_end batch (pkt_id=0x0005) with 3 cores busy: start_data_tx with core_wr_en=0, then DRAIN. After the 3 core_done pulses, pkt_done=1 for 1 cycle, pkt_done_id=0x0005, pkt_cand_count equals the dispatched count.
- Same-cycle dispatch to core 1 and core_done[3]: outstanding unchanged, busy[1]=1, busy[3]=0.
- core_done[0] while core 0 not busy -> error=2'b10, no further start pulses. data_tx_done in IDLE (separate run) -> error=2'b01.
- rst asserted during DATA_WAIT: the next cycle all outputs are 0, and the following dispatch is an init to core 0.

Source files
------------

// File: rtl/bcrypt_tx_arbiter.sv
// Round-robin arbiter that sequences init loads and data batches from one broadcaster
// onto N_CORES bcrypt cores sharing a bus, with per-packet drain and completion accounting.
module bcrypt_tx_arbiter #(
    parameter int N_CORES = 4,
    parameter int CNT_W   = 16
) (
    input  logic               CLK,
    input  logic               rst,
    input  logic               data_ready,
    input  logic               init_ready,
    input  logic [15:0]        bcdata_pkt_id,
    input  logic               bcdata_gen_end,
    output logic               start_init_tx,
    output logic               start_data_tx,
    input  logic               init_tx_done,
    input  logic               data_tx_done,
    input  logic [N_CORES-1:0] core_ready,
    input  logic [N_CORES-1:0] core_done,
    output logic [N_CORES-1:0] core_wr_en,
    output logic               pkt_done,
    output logic [15:0]        pkt_done_id,
    output logic [CNT_W-1:0]   pkt_cand_count,
    output logic [1:0]         error
);

    localparam int IDX_W = $clog2(N_CORES);
    localparam int OUT_W = $clog2(N_CORES + 1);

    typedef enum logic [2:0] {
        IDLE,
        INIT_WAIT,
        DATA_WAIT,
        GEN_END_WAIT,
        DRAIN,
        PKT_DONE,
        ERROR
    } state_t;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   rr_reg, rr_next;
    logic [N_CORES-1:0] busy_reg, busy_next;
    logic [N_CORES-1:0] init_done_reg, init_done_next;
    logic [OUT_W-1:0]   outstanding_reg, outstanding_next;
    logic [CNT_W-1:0]   cand_reg, cand_next;
    logic [N_CORES-1:0] wr_en_reg, wr_en_next;
    logic               start_init_reg, start_init_next;
    logic               start_data_reg, start_data_next;
    logic [15:0]        pkt_id_reg, pkt_id_next;
    logic [1:0]         error_reg, error_next;

    logic [N_CORES-1:0] init_elig;
    logic [N_CORES-1:0] data_elig;
    logic [IDX_W:0]     init_pick;
    logic [IDX_W:0]     data_pick;
    logic [OUT_W-1:0]   done_cnt;
    logic               dispatch;
    logic               tx_err;
    logic               done_err;

    genvar gi;
    generate
        for (gi = 0; gi < N_CORES; gi++) begin : g_elig
            assign init_elig[gi] = core_ready[gi] & ~busy_reg[gi] & ~init_done_reg[gi];
            assign data_elig[gi] = core_ready[gi] & ~busy_reg[gi] &  init_done_reg[gi];
        end
    endgenerate

    // Returns {found, index} of the first requester at or after ptr, wrapping.
    function automatic logic [IDX_W:0] rr_pick(input logic [N_CORES-1:0] req,
                                               input logic [IDX_W-1:0]   ptr);
        logic [IDX_W:0] res;
        int             idx;
        res = '0;
        for (int k = 0; k < N_CORES; k++) begin
            idx = (int'(ptr) + k) % N_CORES;
            if (!res[IDX_W] && req[idx]) begin
                res = {1'b1, IDX_W'(idx)};
            end
        end
        return res;
    endfunction

    assign init_pick = rr_pick(init_elig, rr_reg);
    assign data_pick = rr_pick(data_elig, rr_reg);

    always_comb begin
        done_cnt = '0;
        for (int k = 0; k < N_CORES; k++) begin
            done_cnt = done_cnt + OUT_W'(core_done[k]);
        end
    end

    assign tx_err   = (init_tx_done && (state_reg != INIT_WAIT)) ||
                      (data_tx_done && (state_reg != DATA_WAIT) && (state_reg != GEN_END_WAIT));
    assign done_err = |(core_done & ~busy_reg);

    always_comb begin
        state_next       = state_reg;
        rr_next          = rr_reg;
        busy_next        = busy_reg;
        init_done_next   = init_done_reg;
        outstanding_next = outstanding_reg;
        cand_next        = cand_reg;
        wr_en_next       = wr_en_reg;
        start_init_next  = 1'b0;
        start_data_next  = 1'b0;
        pkt_id_next      = pkt_id_reg;
        error_next       = error_reg;
        dispatch         = 1'b0;

        if (state_reg != ERROR) begin
            busy_next = busy_reg & ~core_done;
            case (state_reg)
                IDLE: begin
                    if (init_pick[IDX_W] && init_ready) begin
                        start_init_next = 1'b1;
                        wr_en_next      = N_CORES'(1) << init_pick[IDX_W-1:0];
                        rr_next         = (init_pick[IDX_W-1:0] == IDX_W'(N_CORES - 1)) ?
                                          '0 : init_pick[IDX_W-1:0] + IDX_W'(1);
                        state_next      = INIT_WAIT;
                    end else if (data_ready && bcdata_gen_end) begin
                        // gen_end dummy goes out on the bus with no core listening
                        pkt_id_next     = bcdata_pkt_id;
                        start_data_next = 1'b1;
                        wr_en_next      = '0;
                        state_next      = GEN_END_WAIT;
                    end else if (data_ready && data_pick[IDX_W]) begin
                        start_data_next = 1'b1;
                        wr_en_next      = N_CORES'(1) << data_pick[IDX_W-1:0];
                        busy_next       = busy_next | (N_CORES'(1) << data_pick[IDX_W-1:0]);
                        dispatch        = 1'b1;
                        if (cand_reg != {CNT_W{1'b1}}) begin
                            cand_next = cand_reg + CNT_W'(1);
                        end
                        rr_next         = (data_pick[IDX_W-1:0] == IDX_W'(N_CORES - 1)) ?
                                          '0 : data_pick[IDX_W-1:0] + IDX_W'(1);
                        state_next      = DATA_WAIT;
                    end
                end
                INIT_WAIT: begin
                    if (init_tx_done) begin
                        init_done_next = init_done_reg | wr_en_reg;
                        wr_en_next     = '0;
                        state_next     = IDLE;
                    end
                end
                DATA_WAIT: begin
                    if (data_tx_done) begin
                        wr_en_next = '0;
                        state_next = IDLE;
                    end
                end
                GEN_END_WAIT: begin
                    if (data_tx_done) begin
                        state_next = DRAIN;
                    end
                end
                PKT_DONE: begin
                    cand_next  = '0;
                    state_next = IDLE;
                end
                default: ;
            endcase

            outstanding_next = outstanding_reg + OUT_W'(dispatch) - done_cnt;
            if ((state_reg == DRAIN) && (outstanding_next == '0)) begin
                state_next = PKT_DONE;
            end

            if (tx_err || done_err) begin
                state_next      = ERROR;
                error_next      = error_reg | {done_err, tx_err};
                wr_en_next      = '0;
                start_init_next = 1'b0;
                start_data_next = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_reg       <= IDLE;
            rr_reg          <= '0;
            busy_reg        <= '0;
            init_done_reg   <= '0;
            outstanding_reg <= '0;
            cand_reg        <= '0;
            wr_en_reg       <= '0;
            start_init_reg  <= 1'b0;
            start_data_reg  <= 1'b0;
            pkt_id_reg      <= '0;
            error_reg       <= '0;
        end else begin
            state_reg       <= state_next;
            rr_reg          <= rr_next;
            busy_reg        <= busy_next;
            init_done_reg   <= init_done_next;
            outstanding_reg <= outstanding_next;
            cand_reg        <= cand_next;
            wr_en_reg       <= wr_en_next;
            start_init_reg  <= start_init_next;
            start_data_reg  <= start_data_next;
            pkt_id_reg      <= pkt_id_next;
            error_reg       <= error_next;
        end
    end

    assign start_init_tx  = start_init_reg;
    assign start_data_tx  = start_data_reg;
    assign core_wr_en     = wr_en_reg;
    assign pkt_done       = (state_reg == PKT_DONE);
    assign pkt_done_id    = (state_reg == PKT_DONE) ? pkt_id_reg : 16'h0000;
    assign pkt_cand_count = (state_reg == PKT_DONE) ? cand_reg : '0;
    assign error          = error_reg;

endmodule

// File: tb/tb_bcrypt_tx_arbiter.sv
// Cycle-accurate directed vectors for bcrypt_tx_arbiter: init/data round-robin,
// packet drain/completion, same-cycle dispatch+done, error traps and mid-transfer reset.
module tb_bcrypt_tx_arbiter;

    logic        CLK;
    logic        rst;
    logic        data_ready;
    logic        init_ready;
    logic [15:0] bcdata_pkt_id;
    logic        bcdata_gen_end;
    logic        start_init_tx;
    logic        start_data_tx;
    logic        init_tx_done;
    logic        data_tx_done;
    logic [3:0]  core_ready;
    logic [3:0]  core_done;
    logic [3:0]  core_wr_en;
    logic        pkt_done;
    logic [15:0] pkt_done_id;
    logic [15:0] pkt_cand_count;
    logic [1:0]  error;

    int n_cmp = 0;
    int n_bad = 0;

    bcrypt_tx_arbiter #(.N_CORES(4), .CNT_W(16)) dut (
        .CLK            (CLK),
        .rst            (rst),
        .data_ready     (data_ready),
        .init_ready     (init_ready),
        .bcdata_pkt_id  (bcdata_pkt_id),
        .bcdata_gen_end (bcdata_gen_end),
        .start_init_tx  (start_init_tx),
        .start_data_tx  (start_data_tx),
        .init_tx_done   (init_tx_done),
        .data_tx_done   (data_tx_done),
        .core_ready     (core_ready),
        .core_done      (core_done),
        .core_wr_en     (core_wr_en),
        .pkt_done       (pkt_done),
        .pkt_done_id    (pkt_done_id),
        .pkt_cand_count (pkt_cand_count),
        .error          (error)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Inputs are applied for one cycle; expected outputs are those seen just after that edge.
    typedef struct packed {
        logic        rst;
        logic        dr;
        logic        ir;
        logic        ge;
        logic [15:0] id;
        logic        itd;
        logic        dtd;
        logic [3:0]  cr;
        logic [3:0]  cd;
        logic        si;
        logic        sd;
        logic [3:0]  wr;
        logic        pd;
        logic [15:0] pid;
        logic [15:0] cnt;
        logic [1:0]  err;
    } vec_t;

    function automatic vec_t v(input int dr, input int ir, input int ge, input int id,
                               input int itd, input int dtd, input int cd,
                               input int si, input int sd, input int wr, input int pd,
                               input int pid, input int cnt, input int err);
        vec_t r;
        r.rst = 1'b0;
        r.dr  = 1'(dr);
        r.ir  = 1'(ir);
        r.ge  = 1'(ge);
        r.id  = 16'(id);
        r.itd = 1'(itd);
        r.dtd = 1'(dtd);
        r.cr  = 4'b1111;
        r.cd  = 4'(cd);
        r.si  = 1'(si);
        r.sd  = 1'(sd);
        r.wr  = 4'(wr);
        r.pd  = 1'(pd);
        r.pid = 16'(pid);
        r.cnt = 16'(cnt);
        r.err = 2'(err);
        return r;
    endfunction

    function automatic vec_t rst_v();
        vec_t r;
        r = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        r.rst = 1'b1;
        return r;
    endfunction

    task automatic run_vec(input vec_t t, input string tag, input int n);
        logic [40:0] got;
        logic [40:0] exp;
        rst            = t.rst;
        data_ready     = t.dr;
        init_ready     = t.ir;
        bcdata_gen_end = t.ge;
        bcdata_pkt_id  = t.id;
        init_tx_done   = t.itd;
        data_tx_done   = t.dtd;
        core_ready     = t.cr;
        core_done      = t.cd;
        @(posedge CLK);
        #1;
        got = {start_init_tx, start_data_tx, core_wr_en, pkt_done, pkt_done_id, pkt_cand_count, error};
        exp = {t.si, t.sd, t.wr, t.pd, t.pid, t.cnt, t.err};
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got si=%b sd=%b wr=%b pd=%b id=%h cnt=%0d err=%b, required si=%b sd=%b wr=%b pd=%b id=%h cnt=%0d err=%b",
                     tag, n, start_init_tx, start_data_tx, core_wr_en, pkt_done, pkt_done_id,
                     pkt_cand_count, error, t.si, t.sd, t.wr, t.pd, t.pid, t.cnt, t.err);
        end else begin
            $display("ok   %s[%0d]: si=%b sd=%b wr=%b pd=%b id=%h cnt=%0d err=%b",
                     tag, n, start_init_tx, start_data_tx, core_wr_en, pkt_done, pkt_done_id,
                     pkt_cand_count, error);
        end
    endtask

    vec_t tbl[$];
    vec_t t;

    initial begin
        rst = 1'b1; data_ready = 1'b0; init_ready = 1'b0; bcdata_pkt_id = '0;
        bcdata_gen_end = 1'b0; init_tx_done = 1'b0; data_tx_done = 1'b0;
        core_ready = 4'b0000; core_done = 4'b0000;

        // ---------------- main table ----------------
        tbl.push_back(rst_v());
        tbl.push_back(rst_v());
        for (int i = 0; i < 4; i++) begin
            tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 1, 0, 1 << i, 0, 0, 0, 0));
            tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 0, 1 << i, 0, 0, 0, 0));
            tbl.push_back(v(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++) begin
            tbl.push_back(v(1, 1, 0, 5, 0, 0, 0, 0, 1, 1 << i, 0, 0, 0, 0));
            tbl.push_back(v(1, 1, 0, 5, 0, 0, 0, 0, 0, 1 << i, 0, 0, 0, 0));
            tbl.push_back(v(1, 1, 0, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        tbl.push_back(v(1, 1, 0, 5, 0, 0, 0,      0, 0, 0,      0, 0, 0, 0));
        tbl.push_back(v(1, 1, 0, 5, 0, 0, 4'b0100, 0, 0, 0,     0, 0, 0, 0));
        tbl.push_back(v(1, 1, 0, 5, 0, 0, 0,      0, 1, 4'b0100, 0, 0, 0, 0));
        tbl.push_back(v(1, 1, 0, 5, 0, 0, 0,      0, 0, 4'b0100, 0, 0, 0, 0));
        tbl.push_back(v(1, 1, 0, 5, 0, 1, 0,      0, 0, 0,      0, 0, 0, 0));
        tbl.push_back(v(1, 1, 0, 5, 0, 0, 4'b0010, 0, 0, 0,     0, 0, 0, 0));
        tbl.push_back(v(1, 1, 0, 5, 0, 0, 4'b1000, 0, 1, 4'b0010, 0, 0, 0, 0));
        tbl.push_back(v(1, 1, 0, 5, 0, 0, 0,      0, 0, 4'b0010, 0, 0, 0, 0));
        tbl.push_back(v(1, 1, 0, 5, 0, 1, 0,      0, 0, 0,      0, 0, 0, 0));
        tbl.push_back(v(1, 1, 1, 5, 0, 0, 0,      0, 1, 0,      0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 0,      0, 0, 0,      0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 1, 0,      0, 0, 0,      0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 4'b0001, 0, 0, 0,     0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 4'b0010, 0, 0, 0,     0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 4'b0100, 0, 0, 0,     1, 16'h0005, 6, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 0,      0, 0, 0,      0, 0, 0, 0));
        tbl.push_back(v(1, 1, 0, 0, 0, 0, 0,      0, 1, 4'b0100, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 0,      0, 0, 4'b0100, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 1, 0,      0, 0, 0,      0, 0, 0, 0));
        tbl.push_back(v(1, 1, 1, 16'h00A3, 0, 0, 0, 0, 1, 0,    0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 1, 0,      0, 0, 0,      0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 4'b0100, 0, 0, 0,     1, 16'h00A3, 1, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 0,      0, 0, 0,      0, 0, 0, 0));

        foreach (tbl[i]) run_vec(tbl[i], "main", i);

        // ---------------- core_done on an idle core ----------------
        run_vec(rst_v(), "err1", 0);
        run_vec(v(0, 0, 0, 0, 0, 0, 4'b0001, 0, 0, 0, 0, 0, 0, 2'b10), "err1", 1);
        for (int i = 2; i < 5; i++) begin
            run_vec(v(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10), "err1", i);
        end

        // ---------------- data_tx_done while IDLE ----------------
        run_vec(rst_v(), "err0", 0);
        run_vec(v(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b01), "err0", 1);
        run_vec(v(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01), "err0", 2);

        // ---------------- reset during DATA_WAIT ----------------
        run_vec(rst_v(), "rstdw", 0);
        t = v(0, 1, 0, 0, 0, 0, 0, 1, 0, 4'b0001, 0, 0, 0, 0); t.cr = 4'b0001; run_vec(t, "rstdw", 1);
        t = v(0, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0001, 0, 0, 0, 0); t.cr = 4'b0001; run_vec(t, "rstdw", 2);
        t = v(0, 1, 0, 0, 1, 0, 0, 0, 0, 0,       0, 0, 0, 0); t.cr = 4'b0001; run_vec(t, "rstdw", 3);
        t = v(1, 1, 0, 0, 0, 0, 0, 0, 1, 4'b0001, 0, 0, 0, 0); t.cr = 4'b0001; run_vec(t, "rstdw", 4);
        t = v(1, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0001, 0, 0, 0, 0); t.cr = 4'b0001; run_vec(t, "rstdw", 5);
        t = rst_v(); t.dr = 1'b1; t.ir = 1'b1; run_vec(t, "rstdw", 6);
        run_vec(v(1, 1, 0, 0, 0, 0, 0, 1, 0, 4'b0001, 0, 0, 0, 0), "rstdw", 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
